// File: rtl/elevator_motion_ctrl.sv
// ------------------------------------------------------------------------
// elevator_motion_ctrl: SCAN-policy car motion sequencer feeding the door
// controller with moving_up / moving_down / floor_reached.   rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module elevator_motion_ctrl #(
  parameter int NUM_FLOORS   = 4,
  parameter int FLOOR_W      = 2,
  parameter int TIMER_W      = 26,
  parameter int TRAVEL_TICKS = 50000000,
  parameter int DWELL_TICKS  = 30000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] req_btn,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  floor_reached,
  output logic [NUM_FLOORS-1:0] pending_req
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    ARRIVE    = 3'd3,
    DWELL     = 3'd4
  } state_t;

  localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_TICKS - 1);
  localparam logic [TIMER_W-1:0] DWELL_LAST  = TIMER_W'(DWELL_TICKS - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  state_t                  state;
  state_t                  state_n;
  logic [FLOOR_W-1:0]      floor_n;
  logic [TIMER_W-1:0]      timer;
  logic [TIMER_W-1:0]      timer_n;
  logic                    last_dir_up;
  logic                    last_dir_up_n;
  logic [NUM_FLOORS-1:0]   pending_n;
  logic [NUM_FLOORS-1:0]   here_mask;
  logic                    calls_above;
  logic                    calls_below;

  always_comb begin
    here_mask   = '0;
    calls_above = 1'b0;
    calls_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      here_mask[i] = (FLOOR_W'(i) == current_floor);
      if (FLOOR_W'(i) > current_floor) calls_above = calls_above | pending_req[i];
      if (FLOOR_W'(i) < current_floor) calls_below = calls_below | pending_req[i];
    end
  end

  always_comb begin
    state_n       = state;
    floor_n       = current_floor;
    timer_n       = timer;
    last_dir_up_n = last_dir_up;
    pending_n     = pending_req | req_btn;

    // The floor being served absorbs any press at that floor, even one arriving this cycle.
    if (state == ARRIVE || state == DWELL) pending_n = pending_n & ~here_mask;

    case (state)
      IDLE: begin
        timer_n = '0;
        if (|(pending_req & here_mask)) begin
          state_n = ARRIVE;
        end else if (last_dir_up && calls_above) begin
          state_n = MOVE_UP;
        end else if (calls_below) begin
          state_n       = MOVE_DOWN;
          last_dir_up_n = 1'b0;
        end else if (calls_above) begin
          state_n       = MOVE_UP;
          last_dir_up_n = 1'b1;
        end
      end
      MOVE_UP: begin
        if (timer == TRAVEL_LAST) begin
          timer_n = '0;
          floor_n = current_floor + 1'b1;
          if (pending_req[floor_n] || floor_n == TOP_FLOOR) state_n = ARRIVE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      MOVE_DOWN: begin
        if (timer == TRAVEL_LAST) begin
          timer_n = '0;
          floor_n = current_floor - 1'b1;
          if (pending_req[floor_n] || floor_n == '0) state_n = ARRIVE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ARRIVE: begin
        timer_n = '0;
        state_n = DWELL;
      end
      DWELL: begin
        if (timer == DWELL_LAST) begin
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: begin
        timer_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      current_floor <= '0;
      timer         <= '0;
      last_dir_up   <= 1'b1;
      pending_req   <= '0;
      moving_up     <= 1'b0;
      moving_down   <= 1'b0;
      floor_reached <= 1'b0;
    end else begin
      state         <= state_n;
      current_floor <= floor_n;
      timer         <= timer_n;
      last_dir_up   <= last_dir_up_n;
      pending_req   <= pending_n;
      moving_up     <= (state_n == MOVE_UP);
      moving_down   <= (state_n == MOVE_DOWN);
      floor_reached <= (state_n == ARRIVE) || (state_n == DWELL);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_elevator_motion_ctrl.sv
// ------------------------------------------------------------------------
// tb_elevator_motion_ctrl: randomized + scenario bench for elevator_motion_ctrl
// against a countdown-based car model.   rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_elevator_motion_ctrl;

  localparam int NF = 4;
  localparam int TT = 10;
  localparam int DT = 20;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_STOP = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NF-1:0] req_btn;
  logic [1:0]    current_floor;
  logic          moving_up;
  logic          moving_down;
  logic          floor_reached;
  logic [NF-1:0] pending_req;

  int checks = 0;
  int errors = 0;

  int       m_mode;
  int       m_floor;
  bit [3:0] m_pend;
  bit       m_up_pref;
  int       m_left;

  elevator_motion_ctrl #(
    .NUM_FLOORS  (NF),
    .FLOOR_W     (2),
    .TIMER_W     (8),
    .TRAVEL_TICKS(TT),
    .DWELL_TICKS (DT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_btn      (req_btn),
    .current_floor(current_floor),
    .moving_up    (moving_up),
    .moving_down  (moving_down),
    .floor_reached(floor_reached),
    .pending_req  (pending_req)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode    = M_IDLE;
    m_floor   = 0;
    m_pend    = '0;
    m_up_pref = 1'b1;
    m_left    = 0;
  endfunction

  // A stop lasts one arrival cycle plus the dwell; a hop lasts TT cycles.
  function automatic void model_step(input logic [3:0] r);
    int       f0;
    bit [3:0] p0;
    bit       above;
    bit       below;
    f0    = m_floor;
    p0    = m_pend;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (p0[i] && i > f0) above = 1'b1;
      if (p0[i] && i < f0) below = 1'b1;
    end
    m_pend = p0 | r;
    if (m_mode == M_STOP) m_pend[f0] = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (p0[f0]) begin
          m_mode = M_STOP; m_left = DT + 1;
        end else if (m_up_pref && above) begin
          m_mode = M_UP; m_left = TT;
        end else if (below) begin
          m_mode = M_DOWN; m_up_pref = 1'b0; m_left = TT;
        end else if (above) begin
          m_mode = M_UP; m_up_pref = 1'b1; m_left = TT;
        end
      end
      M_UP, M_DOWN: begin
        m_left--;
        if (m_left == 0) begin
          m_floor = (m_mode == M_UP) ? m_floor + 1 : m_floor - 1;
          if (p0[m_floor] || m_floor == 0 || m_floor == NF - 1) begin
            m_mode = M_STOP; m_left = DT + 1;
          end else begin
            m_left = TT;
          end
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
    endcase
  endfunction

  function automatic logic [8:0] exp_vec();
    return {2'(m_floor), m_mode == M_UP, m_mode == M_DOWN, m_mode == M_STOP, m_pend};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {current_floor, moving_up, moving_down, floor_reached, pending_req};
  endfunction

  task automatic step(input logic [3:0] r);
    req_btn = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  // Positions the car (per the model) at floor f, idle with no calls.
  task automatic move_to(input int f);
    if (m_floor != f) begin
      step(4'(1 << f));
      for (int i = 0; i < 500 && !(m_mode == M_IDLE && m_pend == 0); i++) step(4'b0000);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ((moving_up && moving_down) || (floor_reached && (moving_up || moving_down))) begin
        errors++;
        $display("FAIL invariant t=%0t: up=%b down=%b reached=%b (required exclusive)",
                 $time, moving_up, moving_down, floor_reached);
      end
    end
  end

  task automatic test_reset();
    rst_n   = 1'b1;
    req_btn = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 9'b0) begin
      errors++; $display("FAIL reset_outputs: got %b required %b", dut_vec(), 9'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 9'b0) begin
      errors++; $display("FAIL reset_held: got %b required %b", dut_vec(), 9'b0);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_travel_up();
    int up_c = 0;
    int fr_c = 0;
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(i == 0 ? 4'b1000 : 4'b0000);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL travel_up cyc %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (moving_up) up_c++;
      if (floor_reached) fr_c++;
      if (m_mode == M_IDLE && m_pend == 0) begin done = 1'b1; break; end
    end
    checks++;
    if (!done || up_c != 3 * TT) begin
      errors++; $display("FAIL travel_up_cycles: got %0d required %0d", up_c, 3 * TT);
    end
    checks++;
    if (fr_c != DT + 1) begin
      errors++; $display("FAIL travel_up_reached: got %0d required %0d", fr_c, DT + 1);
    end
    checks++;
    if (current_floor !== 2'd3 || pending_req !== 4'b0000) begin
      errors++; $display("FAIL travel_up_final: got floor %0d pend %b required 3 0000",
                         current_floor, pending_req);
    end
  endtask

  task automatic test_same_floor();
    int mv_c = 0;
    int fr_c = 0;
    move_to(2);
    for (int i = 0; i < 100; i++) begin
      step(i == 0 ? 4'b0100 : 4'b0000);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL same_floor cyc %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (moving_up || moving_down) mv_c++;
      if (floor_reached) fr_c++;
      if (m_mode == M_IDLE && m_pend == 0) break;
    end
    checks++;
    if (mv_c != 0 || fr_c != DT + 1) begin
      errors++; $display("FAIL same_floor_motion: got moving %0d reached %0d required 0 %0d",
                         mv_c, fr_c, DT + 1);
    end
    checks++;
    if (current_floor !== 2'd2 || pending_req[2] !== 1'b0) begin
      errors++; $display("FAIL same_floor_final: got floor %0d bit2 %b required 2 0",
                         current_floor, pending_req[2]);
    end
  endtask

  task automatic test_on_the_way();
    int  stops[$];
    bit  prev_fr = 1'b0;
    move_to(0);
    for (int i = 0; i < 300; i++) begin
      step(i == 0 ? 4'b1000 : (i == 4 ? 4'b0010 : 4'b0000));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL on_the_way cyc %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (floor_reached && !prev_fr) stops.push_back(int'(current_floor));
      prev_fr = floor_reached;
      if (m_mode == M_IDLE && m_pend == 0) break;
    end
    checks++;
    if (stops.size() != 2 || stops[0] != 1 || stops[1] != 3) begin
      errors++; $display("FAIL on_the_way_stops: got %p required '{1,3}", stops);
    end
  endtask

  task automatic test_scan();
    int  stops[$];
    bit  prev_fr = 1'b0;
    move_to(0);
    move_to(2);
    for (int i = 0; i < 400; i++) begin
      step(i == 0 ? 4'b1001 : 4'b0000);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL scan cyc %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (floor_reached && !prev_fr) stops.push_back(int'(current_floor));
      prev_fr = floor_reached;
      if (m_mode == M_IDLE && m_pend == 0) break;
    end
    checks++;
    if (stops.size() != 2 || stops[0] != 3 || stops[1] != 0) begin
      errors++; $display("FAIL scan_order: got %p required '{3,0}", stops);
    end
  endtask

  task automatic test_dwell_press();
    int fr_c = 0;
    move_to(0);
    for (int i = 0; i < 200; i++) begin
      step(i == 0 ? 4'b0010 : ((fr_c >= 5 && fr_c < 9) ? 4'b0010 : 4'b0000));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL dwell_press cyc %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (floor_reached) fr_c++;
      if (fr_c >= 2 && floor_reached) begin
        checks++;
        if (pending_req[1] !== 1'b0) begin
          errors++; $display("FAIL dwell_press_bit cyc %0d: got %b required 0", i, pending_req[1]);
        end
      end
      if (m_mode == M_IDLE && m_pend == 0) break;
    end
    checks++;
    if (fr_c != DT + 1) begin
      errors++; $display("FAIL dwell_press_length: got %0d required %0d", fr_c, DT + 1);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 14) == 0 && i < 1200) ? 4'($urandom_range(1, 15)) : 4'b0000;
      step(r);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d req %b: got %b expected %b", i, r, dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 400 && !(m_mode == M_IDLE && m_pend == 0); i++) step(4'b0000);
  endtask

  task automatic test_reset_midmove();
    bit found = 1'b0;
    move_to(0);
    for (int i = 0; i < 100; i++) begin
      step(i == 0 ? 4'b1000 : 4'b0000);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL midmove_approach cyc %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (current_floor == 2'd1 && moving_up) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midmove_timeout: got floor %0d up %b required 1 1", current_floor, moving_up);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 9'b0) begin
      errors++; $display("FAIL reset_midmove: got %b required %b", dut_vec(), 9'b0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(4'b0000);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL after_reset cyc %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_travel_up();
    test_same_floor();
    test_on_the_way();
    test_scan();
    test_dwell_press();
    test_random();
    test_reset_midmove();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
